// File: rtl/ram_io_responder_pkg.sv
// Shared definitions for ram_io_responder: IO window decode constants,
// status bit positions and the bus access classification.
package ram_io_responder_pkg;

    localparam logic [1:0] IO_REGION     = 2'b11;
    localparam logic [2:0] IO_DATA_OFS   = 3'd0;
    localparam logic [2:0] IO_STATUS_OFS = 3'd4;

    localparam int unsigned ST_RX_NONEMPTY = 0;
    localparam int unsigned ST_BUF_FULL    = 1;
    localparam int unsigned ST_TX_OVERFLOW = 2;

    typedef enum logic [2:0] {
        OP_RAM_RD,
        OP_RAM_WR,
        OP_IO_DATA_RD,
        OP_IO_DATA_WR,
        OP_IO_STAT_RD,
        OP_IO_RD_ZERO,
        OP_IO_WR_IGNORE
    } op_t;

    function automatic op_t decode_op(input logic       rw,
                                      input logic [1:0] region,
                                      input logic [2:0] ofs);
        if (region != IO_REGION)
            return rw ? OP_RAM_WR : OP_RAM_RD;
        if (ofs == IO_DATA_OFS)
            return rw ? OP_IO_DATA_WR : OP_IO_DATA_RD;
        // STATUS is read-only; a write there behaves like a reserved offset
        if (!rw && ofs == IO_STATUS_OFS)
            return OP_IO_STAT_RD;
        return rw ? OP_IO_WR_IGNORE : OP_IO_RD_ZERO;
    endfunction

endpackage

// File: rtl/ram_io_responder_if.sv
// RAM-port bus and UART byte streams between the memory controller side and
// ram_io_responder.
interface ram_io_responder_if;

    logic        rw_select;
    logic [17:0] addr_in;
    logic [7:0]  ram_store_data;
    logic [7:0]  ram_load_data;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;

    modport master (
        output rw_select, addr_in, ram_store_data, tx_ready, rx_data, rx_valid,
        input  ram_load_data, io_buffer_full, tx_data, tx_valid
    );

    modport slave (
        input  rw_select, addr_in, ram_store_data, tx_ready, rx_data, rx_valid,
        output ram_load_data, io_buffer_full, tx_data, tx_valid
    );

endinterface

// File: rtl/ram_io_responder_byte_fifo.sv
// Byte FIFO with a show-ahead head; pushes while full are dropped and the
// head reads as 0x00 while empty.
module byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [7:0]               i_data,
    output logic [7:0]               o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_count   = r_count;
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk_in) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push_ok && !w_pop_ok)
                r_count <= r_count + CW'(1);
            else if (!w_push_ok && w_pop_ok)
                r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/ram_io_responder.sv
// Byte-wide RAM plus UART IO window responder for the controller RAM port.
// Define IO_STATUS_EN to implement the STATUS register and sticky tx_overflow.
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = 17,
    parameter int unsigned TX_DEPTH       = 8,
    parameter int unsigned RX_DEPTH       = 8
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    ram_io_responder_if.slave bus
);

    localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;

    logic [7:0]          r_mem [2**RAM_ADDR_WIDTH];
    logic [7:0]          r_load_data;
    logic                r_io_buffer_full;
    op_t                 w_op;
    logic [RAM_ADDR_WIDTH-1:0] w_ram_addr;

    logic                w_tx_push, w_tx_pop, w_tx_empty, w_tx_full;
    logic                w_tx_push_ok, w_tx_pop_ok;
    logic [TX_CW-1:0]    w_tx_count, w_tx_count_next;
    logic [7:0]          w_tx_head;

    logic                w_rx_push, w_rx_pop, w_rx_empty, w_rx_full;
    logic [RX_CW-1:0]    w_rx_count;
    logic [7:0]          w_rx_head;
    logic [7:0]          w_status;
    logic                w_unused_rx;

    assign w_op       = decode_op(bus.rw_select, bus.addr_in[17:16], bus.addr_in[2:0]);
    assign w_ram_addr = bus.addr_in[RAM_ADDR_WIDTH-1:0];

    // UART-side handshakes are qualified by rdy_in as well as the bus side
    assign w_tx_push = rdy_in && (w_op == OP_IO_DATA_WR);
    assign w_tx_pop  = rdy_in && bus.tx_ready;
    assign w_rx_push = rdy_in && bus.rx_valid;
    assign w_rx_pop  = rdy_in && (w_op == OP_IO_DATA_RD);

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .i_push   (w_tx_push),
        .i_pop    (w_tx_pop),
        .i_data   (bus.ram_store_data),
        .o_data   (w_tx_head),
        .o_count  (w_tx_count),
        .o_empty  (w_tx_empty),
        .o_full   (w_tx_full)
    );

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .i_push   (w_rx_push),
        .i_pop    (w_rx_pop),
        .i_data   (bus.rx_data),
        .o_data   (w_rx_head),
        .o_count  (w_rx_count),
        .o_empty  (w_rx_empty),
        .o_full   (w_rx_full)
    );

    assign w_unused_rx = &{1'b0, w_rx_count, w_rx_full};

    assign w_tx_push_ok    = w_tx_push && !w_tx_full;
    assign w_tx_pop_ok     = w_tx_pop && !w_tx_empty;
    assign w_tx_count_next = w_tx_count + TX_CW'(w_tx_push_ok) - TX_CW'(w_tx_pop_ok);

`ifdef IO_STATUS_EN
    logic r_tx_overflow;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            r_tx_overflow <= 1'b0;
        else if (rdy_in) begin
            if (w_op == OP_IO_DATA_WR && w_tx_full)
                r_tx_overflow <= 1'b1;
            else if (w_op == OP_IO_STAT_RD)
                r_tx_overflow <= 1'b0;
        end
    end

    always_comb begin
        w_status                 = '0;
        w_status[ST_RX_NONEMPTY] = !w_rx_empty;
        w_status[ST_BUF_FULL]    = r_io_buffer_full;
        w_status[ST_TX_OVERFLOW] = r_tx_overflow;
    end
`else
    assign w_status = '0;
`endif

    always_ff @(posedge clk_in) begin
        if (rdy_in && w_op == OP_RAM_WR)
            r_mem[w_ram_addr] <= bus.ram_store_data;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_load_data      <= '0;
            r_io_buffer_full <= 1'b0;
        end else if (rdy_in) begin
            // Threshold on the post-edge count keeps 4 free slots for a burst
            r_io_buffer_full <= (w_tx_count_next >= TX_CW'(TX_DEPTH - 4));
            unique case (w_op)
                OP_RAM_RD:     r_load_data <= r_mem[w_ram_addr];
                OP_IO_DATA_RD: r_load_data <= w_rx_head;
                OP_IO_STAT_RD: r_load_data <= w_status;
                OP_IO_RD_ZERO: r_load_data <= '0;
                default:       r_load_data <= r_load_data;
            endcase
        end
    end

    assign bus.ram_load_data  = r_load_data;
    assign bus.io_buffer_full = r_io_buffer_full;
    assign bus.tx_data        = w_tx_head;
    assign bus.tx_valid       = !w_tx_empty;

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed self-checking bench for ram_io_responder: a vector table for RAM
// and decode behaviour plus hand-written FIFO, status and reset sequences.
module tb_ram_io_responder;

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

`ifdef IO_STATUS_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    ram_io_responder_if bus();

    ram_io_responder #(
        .RAM_ADDR_WIDTH (17),
        .TX_DEPTH       (8),
        .RX_DEPTH       (8)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        rw;
        logic [17:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_load;
    } vec_t;

    vec_t vecs[19];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_op(input logic rw, input logic [17:0] a, input logic [7:0] d);
        bus.rw_select      = rw;
        bus.addr_in        = a;
        bus.ram_store_data = d;
        step();
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 18'h01234, 8'hA5, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 18'h01234, 8'h00, 8'hA5};
        vecs[2]  = '{1'b1, 1'b1, 18'h00100, 8'h11, 8'hA5};
        vecs[3]  = '{1'b1, 1'b1, 18'h00101, 8'h22, 8'hA5};
        vecs[4]  = '{1'b1, 1'b1, 18'h00102, 8'h33, 8'hA5};
        vecs[5]  = '{1'b1, 1'b1, 18'h00103, 8'h44, 8'hA5};
        vecs[6]  = '{1'b1, 1'b0, 18'h00100, 8'h00, 8'h11};
        vecs[7]  = '{1'b1, 1'b0, 18'h00101, 8'h00, 8'h22};
        vecs[8]  = '{1'b1, 1'b0, 18'h00102, 8'h00, 8'h33};
        vecs[9]  = '{1'b1, 1'b0, 18'h00103, 8'h00, 8'h44};
        vecs[10] = '{1'b0, 1'b1, 18'h01234, 8'hFF, 8'h44};
        vecs[11] = '{1'b0, 1'b0, 18'h00100, 8'h00, 8'h44};
        vecs[12] = '{1'b1, 1'b0, 18'h01234, 8'h00, 8'hA5};
        vecs[13] = '{1'b1, 1'b0, 18'h30001, 8'h00, 8'h00};
        vecs[14] = '{1'b1, 1'b0, 18'h20100, 8'h00, 8'h11};
        vecs[15] = '{1'b1, 1'b1, 18'h30005, 8'h99, 8'h11};
        vecs[16] = '{1'b1, 1'b1, 18'h1FFFF, 8'h5C, 8'h11};
        vecs[17] = '{1'b1, 1'b0, 18'h1FFFF, 8'h00, 8'h5C};
        vecs[18] = '{1'b1, 1'b0, 18'h30007, 8'h00, 8'h00};

        rst_n              = 1'b0;
        rdy                = 1'b1;
        bus.rw_select      = 1'b0;
        bus.addr_in        = '0;
        bus.ram_store_data = '0;
        bus.tx_ready       = 1'b0;
        bus.rx_data        = '0;
        bus.rx_valid       = 1'b0;
        #3;
        chk("reset_load", bus.ram_load_data, 8'h00);
        chk("reset_full", {7'b0, bus.io_buffer_full}, 8'h00);
        chk("reset_txv",  {7'b0, bus.tx_valid}, 8'h00);
        chk("reset_txd",  bus.tx_data, 8'h00);
        step();
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            rdy = vecs[i].rdy;
            bus_op(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d_load", i), bus.ram_load_data, vecs[i].exp_load);
        end
        rdy = 1'b1;
        chk("table_txv_idle", {7'b0, bus.tx_valid}, 8'h00);

        // single TX byte, then one-cycle UART pop
        bus_op(1'b1, 18'h30000, 8'h41);
        chk("tx_single_valid", {7'b0, bus.tx_valid}, 8'h01);
        chk("tx_single_data", bus.tx_data, 8'h41);
        bus.tx_ready = 1'b1;
        bus_op(1'b0, 18'h00000, 8'h00);
        bus.tx_ready = 1'b0;
        chk("tx_pop_valid", {7'b0, bus.tx_valid}, 8'h00);
        chk("tx_pop_data", bus.tx_data, 8'h00);

        // simultaneous push and pop
        bus_op(1'b1, 18'h30000, 8'hB1);
        chk("tx_b1_head", bus.tx_data, 8'hB1);
        bus.tx_ready = 1'b1;
        bus_op(1'b1, 18'h30000, 8'hB2);
        chk("tx_pushpop_head", bus.tx_data, 8'hB2);
        chk("tx_pushpop_valid", {7'b0, bus.tx_valid}, 8'h01);
        bus_op(1'b0, 18'h00000, 8'h00);
        chk("tx_pushpop_drain", {7'b0, bus.tx_valid}, 8'h00);
        bus.tx_ready = 1'b0;

        // tx_ready ignored while frozen
        bus_op(1'b1, 18'h30000, 8'hC3);
        bus.rw_select = 1'b0;
        bus.addr_in   = 18'h00000;
        rdy           = 1'b0;
        bus.tx_ready  = 1'b1;
        step();
        chk("freeze_txv", {7'b0, bus.tx_valid}, 8'h01);
        chk("freeze_txd", bus.tx_data, 8'hC3);
        rdy = 1'b1;
        step();
        chk("unfreeze_pop", {7'b0, bus.tx_valid}, 8'h00);
        bus.tx_ready = 1'b0;

        // burst fill to overflow
        for (int i = 1; i <= 10; i++) begin
            bus_op(1'b1, 18'h30000, 8'(i));
            chk($sformatf("burst%0d_full", i), {7'b0, bus.io_buffer_full},
                (i >= 4) ? 8'h01 : 8'h00);
        end
        chk("burst_head", bus.tx_data, 8'h01);
        bus_op(1'b0, 18'h30004, 8'h00);
        chk("status_ovf", bus.ram_load_data, STAT_EN ? 8'h06 : 8'h00);
        bus_op(1'b0, 18'h30004, 8'h00);
        chk("status_reread", bus.ram_load_data, STAT_EN ? 8'h02 : 8'h00);

        bus.rw_select = 1'b0;
        bus.addr_in   = 18'h00000;
        bus.tx_ready  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain%0d_data", i), bus.tx_data, 8'(i));
            step();
            chk($sformatf("drain%0d_full", i), {7'b0, bus.io_buffer_full},
                (8 - i >= 4) ? 8'h01 : 8'h00);
        end
        chk("drain_empty", {7'b0, bus.tx_valid}, 8'h00);
        bus.tx_ready = 1'b0;

        // RX path
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h7E;
        bus_op(1'b0, 18'h00000, 8'h00);
        bus.rx_data  = 8'h7F;
        bus_op(1'b0, 18'h00000, 8'h00);
        bus.rx_valid = 1'b0;
        bus_op(1'b0, 18'h30004, 8'h00);
        chk("status_rxne", bus.ram_load_data, STAT_EN ? 8'h01 : 8'h00);
        bus_op(1'b0, 18'h30000, 8'h00);
        chk("rx_rd0", bus.ram_load_data, 8'h7E);
        bus_op(1'b0, 18'h30000, 8'h00);
        chk("rx_rd1", bus.ram_load_data, 8'h7F);
        bus_op(1'b0, 18'h30000, 8'h00);
        chk("rx_rd_empty", bus.ram_load_data, 8'h00);
        bus_op(1'b0, 18'h30004, 8'h00);
        chk("status_rx_clear", bus.ram_load_data, 8'h00);

        // RX overflow: ninth byte dropped
        for (int i = 0; i < 9; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'h50 + 8'(i);
            bus_op(1'b0, 18'h00000, 8'h00);
        end
        bus.rx_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus_op(1'b0, 18'h30000, 8'h00);
            chk($sformatf("rxovf_rd%0d", i), bus.ram_load_data,
                (i < 8) ? 8'h50 + 8'(i) : 8'h00);
        end

        // simultaneous RX push and bus pop
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h61;
        bus_op(1'b0, 18'h00000, 8'h00);
        bus.rx_data  = 8'h62;
        bus_op(1'b0, 18'h30000, 8'h00);
        bus.rx_valid = 1'b0;
        chk("rx_pushpop_rd0", bus.ram_load_data, 8'h61);
        bus_op(1'b0, 18'h30000, 8'h00);
        chk("rx_pushpop_rd1", bus.ram_load_data, 8'h62);
        bus_op(1'b0, 18'h30000, 8'h00);
        chk("rx_pushpop_empty", bus.ram_load_data, 8'h00);

        // rx_valid ignored while frozen
        rdy          = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hEE;
        step();
        rdy          = 1'b1;
        bus.rx_valid = 1'b0;
        bus_op(1'b0, 18'h30000, 8'h00);
        chk("rx_freeze_drop", bus.ram_load_data, 8'h00);

        // asynchronous reset mid-burst
        bus_op(1'b1, 18'h00200, 8'h77);
        bus_op(1'b0, 18'h00200, 8'h00);
        chk("pre_reset_load", bus.ram_load_data, 8'h77);
        for (int i = 0; i < 4; i++)
            bus_op(1'b1, 18'h30000, 8'hD0 + 8'(i));
        chk("pre_reset_full", {7'b0, bus.io_buffer_full}, 8'h01);
        chk("pre_reset_txv", {7'b0, bus.tx_valid}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_load", bus.ram_load_data, 8'h00);
        chk("async_rst_full", {7'b0, bus.io_buffer_full}, 8'h00);
        chk("async_rst_txv", {7'b0, bus.tx_valid}, 8'h00);
        chk("async_rst_txd", bus.tx_data, 8'h00);
        step();
        rst_n = 1'b1;
        bus_op(1'b0, 18'h00200, 8'h00);
        chk("post_reset_ram0", bus.ram_load_data, 8'h77);
        bus_op(1'b0, 18'h01234, 8'h00);
        chk("post_reset_ram1", bus.ram_load_data, 8'hA5);
        chk("post_reset_txv", {7'b0, bus.tx_valid}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
